serial_subtractor: RTL and testbench
====================================

// Module: serial_subtractor
// PURPOSE
//  Bit-serial WIDTH-bit subtractor: computes diff = a - b, LSB first, one bit per clock.
//  Reverse-direction companion to the combinational half-adder datapath; built from
//  half-subtractor cells plus a borrow flop.
//  Used where area matters more than latency. Start/done handshake to a control FSM upstream.
// PARAMETERS
//  WIDTH   4   operand/result width in bits; legal range 2..32
// PORTS
//  clk         in   1      rising-edge clock, single clock domain
//  rst_n       in   1      asynchronous active-low reset
//  start       in   1      request; sampled only when busy==0
//  a           in   WIDTH  minuend; sampled with start
//  b           in   WIDTH  subtrahend; sampled with start
//  busy        out  1      high while a subtraction is in progress
//  done        out  1      one-cycle pulse; diff/borrow_out valid from this cycle on
//  diff        out  WIDTH  a - b modulo 2^WIDTH
//  borrow_out  out  1      1 when a < b (unsigned)
//  ovf         out  1      signed overflow; present only with SERIAL_SUB_OVF_EN
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; busy, done, diff, borrow_out, ovf, borrow flop,
//  bit counter and operand shift registers all 0. Takes effect immediately and aborts
//  any operation in progress. No done pulse follows the abort.
//  FSM, two states:
//   IDLE: start=1 at a clk edge -> load a_sr=a, b_sr=b, borrow=0, cnt=0 -> RUN.
//   RUN:  each edge: d = a_sr[0]^b_sr[0]^borrow;
//         borrow <= (~a_sr[0]&b_sr[0]) | (~(a_sr[0]^b_sr[0])&borrow);
//         a_sr, b_sr shift right; d shifts into the result MSB; cnt++.
//         When cnt==WIDTH-1 -> IDLE, done<=1, diff<=final result, borrow_out<=final borrow.
//  Timing: start high in cycle 0 -> busy=1 in cycles 1..WIDTH -> done=1 and busy=0 in cycle WIDTH+1.
//  Latency is exactly WIDTH+1 cycles from start to done.
//  done is high for exactly one cycle. diff/borrow_out hold until the next completion.
//  They do not change during a subsequent RUN.
//  start while busy=1 is ignored; no queuing.
//  start during the done cycle is accepted: back-to-back operations, zero idle cycles.
//  a/b are don't-care except in the sampling cycle.
//  Arithmetic: two's-complement modulo 2^WIDTH. Examples: 0-1 -> diff=all ones, borrow_out=1.
//  Equal operands -> diff=0, borrow_out=0.
// CONFIGURATION
//  SERIAL_SUB_OVF_EN defined: ovf port exists. At the final bit,
//   ovf <= (a_msb != b_msb) && (d != a_msb), updated with diff. Reset 0.
//  Undefined: no ovf port, no ovf logic; all other behaviour identical.
// STRUCTURE
//  serial_sub_pkg: state encoding (IDLE=1'b0, RUN=1'b1) and the default WIDTH localparam.
//  Sub-module half_subtractor (x, y -> d = x^y, bo = ~x&y).
//  Two instances plus an OR form the full-subtractor bit cell.
//  Top level holds the FSM, counter ($clog2(WIDTH) bits), shift registers and output registers.
// TESTING (WIDTH=4)
//  1. Reset, then a=9, b=5, start -> done in cycle 5, diff=4, borrow_out=0, busy high in cycles 1-4.
//  2. a=3, b=5 -> diff=14, borrow_out=1. Then a=0, b=1 -> diff=15, borrow_out=1.
//  3. a=7, b=7 -> diff=0, borrow_out=0. Then start in the done cycle with a=12, b=2:
//     diff=10, with done exactly 5 cycles after the first done.
//  4. start pulses in cycles 2-3 of a running op -> ignored; single done; diff from the first operands.
//  5. rst_n low in cycle 2 of a run -> busy, done and diff go to 0 immediately.
//     No done follows; next op (6-1) gives diff=5.
//  6. SERIAL_SUB_OVF_EN: a=8 (-8), b=1 -> diff=7, ovf=1. a=2, b=1 -> diff=1, ovf=0.
//  All cases: scoreboard diff == (a-b) mod 16 and borrow_out == (a<b) on every done.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and default width.
package serial_sub_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam int WIDTH_DEFAULT = 4;

endpackage

// File: rtl/serial_subtractor_hs.sv
// Half-subtractor cell: difference and borrow of x - y for a single bit.
module half_subtractor (
   input  logic x,
   input  logic y,
   output logic d,
   output logic bo
);

   assign d  = x ^ y;
   assign bo = ~x & y;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (diff = a - b, LSB first, one bit per clock).
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] res_sr;
   logic             borrow;

   logic             d1;
   logic             bo1;
   logic             d;
   logic             bo2;
   logic             borrow_next;
   logic [WIDTH-1:0] res_next;

   // Full-subtractor bit cell: two half-subtractors chained, borrows merged by OR.
   half_subtractor u_hs_ab (
      .x  (a_sr[0]),
      .y  (b_sr[0]),
      .d  (d1),
      .bo (bo1)
   );

   half_subtractor u_hs_borrow (
      .x  (d1),
      .y  (borrow),
      .d  (d),
      .bo (bo2)
   );

   assign borrow_next = bo1 | bo2;
   assign res_next    = {d, res_sr[WIDTH-1:1]};

   // diff/borrow_out are only written on completion, so they stay stable during a later run.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         a_sr       <= '0;
         b_sr       <= '0;
         res_sr     <= '0;
         borrow     <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         diff       <= '0;
         borrow_out <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
         ovf        <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  a_sr   <= a;
                  b_sr   <= b;
                  res_sr <= '0;
                  borrow <= 1'b0;
                  cnt    <= '0;
                  busy   <= 1'b1;
                  state  <= RUN;
               end
            end
            RUN: begin
               a_sr   <= a_sr >> 1;
               b_sr   <= b_sr >> 1;
               res_sr <= res_next;
               borrow <= borrow_next;
               cnt    <= cnt + 1'b1;
               if (cnt == CNT_LAST) begin
                  state      <= IDLE;
                  busy       <= 1'b0;
                  done       <= 1'b1;
                  diff       <= res_next;
                  borrow_out <= borrow_next;
`ifdef SERIAL_SUB_OVF_EN
                  ovf        <= (a_sr[0] != b_sr[0]) && (d != a_sr[0]);
`endif
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=4): directed cases plus random ops vs. an arithmetic model.
// Checks ovf as well when built with SERIAL_SUB_OVF_EN.
module tb_serial_subtractor;

   localparam int W = 4;
   localparam int MOD = 1 << W;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] diff;
   logic         borrow_out;
`ifdef SERIAL_SUB_OVF_EN
   logic         ovf;
`endif

   int testCount = 0;
   int failCount = 0;
   int lastDiff = 0;
   int lastBorrow = 0;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .a          (a),
      .b          (b),
      .busy       (busy),
      .done       (done),
      .diff       (diff),
      .borrow_out (borrow_out)
`ifdef SERIAL_SUB_OVF_EN
      ,
      .ovf        (ovf)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input int observed, input int expected);
      testCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Caller is at a negedge; on return we are at the negedge of the done cycle.
   task automatic applyStimulus(input int opA, input int opB, input bit pokeStart);
      int expDiff;
      int expBorrow;
      int sa;
      int sb;
      int sres;
      int expOvf;
      expDiff   = ((opA - opB) % MOD + MOD) % MOD;
      expBorrow = (opA < opB) ? 1 : 0;
      sa        = (opA >= MOD / 2) ? opA - MOD : opA;
      sb        = (opB >= MOD / 2) ? opB - MOD : opB;
      sres      = sa - sb;
      expOvf    = (sres < -(MOD / 2) || sres > (MOD / 2 - 1)) ? 1 : 0;
      a     = W'(opA);
      b     = W'(opB);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      a     = W'($urandom);
      b     = W'($urandom);
      for (int c = 1; c <= W; c++) begin
         @(negedge clk);
         checkOutput("busy_run", int'(busy), 1);
         checkOutput("done_run", int'(done), 0);
         checkOutput("diff_hold", int'(diff), lastDiff);
         checkOutput("borrow_hold", int'(borrow_out), lastBorrow);
         if (pokeStart && (c == 2 || c == 3)) begin
            start = 1'b1;
            a     = W'($urandom);
            b     = W'($urandom);
         end else if (pokeStart && c == 4) begin
            start = 1'b0;
         end
      end
      @(negedge clk);
      checkOutput("done_pulse", int'(done), 1);
      checkOutput("busy_done", int'(busy), 0);
      checkOutput("diff", int'(diff), expDiff);
      checkOutput("borrow_out", int'(borrow_out), expBorrow);
`ifdef SERIAL_SUB_OVF_EN
      checkOutput("ovf", int'(ovf), expOvf);
`endif
      if (expOvf > 1) $display("[TB] unexpected overflow model value");
      lastDiff   = expDiff;
      lastBorrow = expBorrow;
   endtask

   task automatic idleCheck();
      @(negedge clk);
      checkOutput("done_single", int'(done), 0);
      checkOutput("busy_idle", int'(busy), 0);
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      a     = '0;
      b     = '0;
      repeat (2) @(negedge clk);
      checkOutput("rst_busy", int'(busy), 0);
      checkOutput("rst_done", int'(done), 0);
      checkOutput("rst_diff", int'(diff), 0);
      checkOutput("rst_borrow", int'(borrow_out), 0);
`ifdef SERIAL_SUB_OVF_EN
      checkOutput("rst_ovf", int'(ovf), 0);
`endif
      rst_n = 1'b1;
      @(negedge clk);

      applyStimulus(9, 5, 1'b0);
      idleCheck();
      applyStimulus(3, 5, 1'b0);
      idleCheck();
      applyStimulus(0, 1, 1'b0);
      idleCheck();
      applyStimulus(7, 7, 1'b0);
      applyStimulus(12, 2, 1'b0);
      idleCheck();
      applyStimulus(10, 3, 1'b1);
      idleCheck();

      // Abort a run with reset in its second busy cycle.
      a     = W'(9);
      b     = W'(2);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      checkOutput("abort_busy", int'(busy), 0);
      checkOutput("abort_done", int'(done), 0);
      checkOutput("abort_diff", int'(diff), 0);
      checkOutput("abort_borrow", int'(borrow_out), 0);
      lastDiff   = 0;
      lastBorrow = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         checkOutput("abort_no_done", int'(done), 0);
         checkOutput("abort_no_busy", int'(busy), 0);
      end
      applyStimulus(6, 1, 1'b0);
      idleCheck();

      applyStimulus(8, 1, 1'b0);
      applyStimulus(2, 1, 1'b0);
      idleCheck();

      for (int i = 0; i < 24; i++) begin
         applyStimulus(int'($urandom_range(0, MOD - 1)), int'($urandom_range(0, MOD - 1)),
                       ($urandom_range(0, 3) == 0));
         if ($urandom_range(0, 1) == 1) idleCheck();
      end
      idleCheck();

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
